muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/rv_pkg.sv | 40 ++++
 rtl/muldiv_ctrl.sv | 159 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV64M definitions: datapath width, funct3 encodings, control states
// and the sign-magnitude helpers used by the iterative multiply/divide unit.
package rv_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x, input logic is_signed);
    return (is_signed && x[XLEN-1]) ? -x : x;
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_if_wide(input logic [2*XLEN-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return {{(XLEN-32){x[31]}}, x};
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Iterative RV64M multiply/divide unit: one radix-2 step per cycle through a shared
// accumulator and a single XLEN+1-bit adder/subtractor, with a sign fix-up cycle.
module muldiv_ctrl
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            is32,
  input  logic            flush,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output state_e          state
);

  localparam int X = XLEN;

  state_e          state_q, state_d;
  logic [2:0]      op_q;
  logic            is32_q;
  logic [X-1:0]    a_q, b_q;
  logic [2*X-1:0]  acc;
  logic [X-1:0]    opnd;
  logic [5:0]      cnt;
  logic            neg_q, rem_neg_q;

  // Operand preparation, evaluated from the latched request during PREP.
  logic            is_mulh, word, is_div, a_signed, b_signed;
  logic [X-1:0]    ext_a, ext_b, mag_a, mag_b, special_res;
  logic            sign_a, sign_b, div_zero, ovf, special;

  always_comb begin
    is_mulh  = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_MULHU);
    word     = is32_q && !is_mulh;
    is_div   = op_q[2];
    a_signed = !((op_q == OP_MULHU) || (op_q == OP_DIVU) || (op_q == OP_REMU));
    b_signed = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
    ext_a    = word ? (a_signed ? sext32(a_q[31:0]) : {{(X-32){1'b0}}, a_q[31:0]}) : a_q;
    ext_b    = word ? (b_signed ? sext32(b_q[31:0]) : {{(X-32){1'b0}}, b_q[31:0]}) : b_q;
    sign_a   = a_signed && ext_a[X-1];
    sign_b   = b_signed && ext_b[X-1];
    mag_a    = abs_val(ext_a, a_signed);
    mag_b    = abs_val(ext_b, b_signed);
    div_zero = is_div && (ext_b == '0);
    ovf      = ((op_q == OP_DIV) || (op_q == OP_REM)) && (&ext_b) &&
               (ext_a == (word ? sext32(32'h8000_0000) : {1'b1, {(X-1){1'b0}}}));
    special  = div_zero || ovf;
    special_res = '0;
    if (div_zero)
      special_res = op_q[1] ? (word ? sext32(a_q[31:0]) : a_q) : '1;
    else if (ovf)
      special_res = op_q[1] ? '0 : ext_a;
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide.
  logic [X:0]     r_sh, add_a, add_b;
  logic [X+1:0]   sum;
  logic [2*X-1:0] acc_step;

  always_comb begin
    r_sh  = {acc[2*X-1:X], acc[X-1]};
    add_a = is_div ? r_sh : {1'b0, acc[2*X-1:X]};
    add_b = is_div ? ~{1'b0, opnd} : {1'b0, opnd};
    sum   = {1'b0, add_a} + {1'b0, add_b} + {{(X+1){1'b0}}, is_div};
    if (is_div)
      acc_step = sum[X+1] ? {sum[X-1:0], acc[X-2:0], 1'b1} : {r_sh[X-1:0], acc[X-2:0], 1'b0};
    else
      acc_step = acc[0] ? {sum[X:0], acc[X-1:1]} : {1'b0, acc[2*X-1:X], acc[X-1:1]};
  end

  // A word multiply leaves its product scaled by 2^32 after only 32 shifts.
  logic [2*X-1:0] prod;
  logic [X-1:0]   quo, rem, sel, fix_res;

  always_comb begin
    prod = neg_if_wide(word ? {32'b0, acc[2*X-1:32]} : acc, neg_q);
    quo  = neg_if(acc[X-1:0], neg_q);
    rem  = neg_if(acc[2*X-1:X], rem_neg_q);
    case (op_q)
      OP_MUL:                     sel = prod[X-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: sel = prod[2*X-1:X];
      OP_DIV, OP_DIVU:            sel = quo;
      default:                    sel = rem;
    endcase
    fix_res = word ? sext32(sel[31:0]) : sel;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_PREP;
        S_PREP:  state_d = special ? S_DONE : S_CALC;
        S_CALC:  if (cnt == 6'd0) state_d = S_FIX;
        S_FIX:   state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ready = (state_q == S_IDLE);
    busy  = !ready;
    done  = (state_q == S_DONE);
    state = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      is32_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      opnd      <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result    <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start && !flush) begin
          op_q   <= op;
          is32_q <= is32;
          a_q    <= a;
          b_q    <= b;
        end
        S_PREP: begin
          opnd      <= is_div ? mag_b : mag_a;
          acc       <= {{X{1'b0}}, is_div ? (word ? (mag_a << 32) : mag_a) : mag_b};
          cnt       <= word ? 6'd31 : 6'd63;
          neg_q     <= sign_a ^ sign_b;
          rem_neg_q <= sign_a;
          if (special && !flush) result <= special_res;
        end
        S_CALC: begin
          acc <= acc_step;
          if (cnt != 6'd0) cnt <= cnt - 6'd1;
        end
        S_FIX: if (!flush) result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed RV64M vectors, random ops against an arithmetic
// reference model, abort/flush/reset-mid-operation and back-to-back scenarios.
module tb_muldiv_ctrl;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        is32 = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] a = '0, b = '0;
  logic        ready, busy, done;
  logic [63:0] result;
  state_e      dbg_state;

  int tot = 0;
  int bad = 0;
  logic [63:0] last_exp = '0;

  muldiv_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .is32(is32), .flush(flush),
    .a(a), .b(b), .ready(ready), .busy(busy), .done(done), .result(result),
    .state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_result(input logic [2:0] f, input logic w,
                                             input logic [63:0] x, input logic [63:0] y);
    logic signed [127:0] pa, pb, p;
    logic signed [63:0]  sx64, sy64;
    logic signed [31:0]  sx32v, sy32v;
    logic [31:0]         ux32, uy32;
    logic [63:0]         lo;
    sx64 = x; sy64 = y; sx32v = x[31:0]; sy32v = y[31:0]; ux32 = x[31:0]; uy32 = y[31:0];
    case (f)
      3'd0: begin lo = x * y; return w ? sx(lo[31:0]) : lo; end
      3'd1: begin pa = sx64; pb = sy64; p = pa * pb; return p[127:64]; end
      3'd2: begin pa = sx64; pb = {64'b0, y}; p = pa * pb; return p[127:64]; end
      3'd3: begin p = {64'b0, x} * {64'b0, y}; return p[127:64]; end
      3'd4: if (w) begin
              if (uy32 == 0) return '1;
              if (ux32 == 32'h8000_0000 && uy32 == 32'hFFFF_FFFF) return sx(ux32);
              return sx(32'(sx32v / sy32v));
            end else begin
              if (y == 0) return '1;
              if (x == 64'h8000_0000_0000_0000 && y == '1) return x;
              return 64'(sx64 / sy64);
            end
      3'd5: if (w) return (uy32 == 0) ? '1 : sx(ux32 / uy32);
            else   return (y == 0) ? '1 : x / y;
      3'd6: if (w) begin
              if (uy32 == 0) return sx(ux32);
              if (ux32 == 32'h8000_0000 && uy32 == 32'hFFFF_FFFF) return '0;
              return sx(32'(sx32v % sy32v));
            end else begin
              if (y == 0) return x;
              if (x == 64'h8000_0000_0000_0000 && y == '1) return '0;
              return 64'(sx64 % sy64);
            end
      default: if (w) return (uy32 == 0) ? sx(ux32) : sx(ux32 % uy32);
               else   return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Cycle in which done must be seen, counting the accept cycle as 0.
  function automatic int ref_latency(input logic [2:0] f, input logic w,
                                     input logic [63:0] x, input logic [63:0] y);
    logic wd;
    wd = w && (f == 3'd0 || f[2]);
    if (f[2]) begin
      if (wd ? (y[31:0] == 0) : (y == 0)) return 2;
      if ((f == 3'd4 || f == 3'd6) &&
          (wd ? (x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF)
              : (x == 64'h8000_0000_0000_0000 && y == '1))) return 2;
    end
    return wd ? 35 : 67;
  endfunction

  // ---------------- driver ----------------
  task automatic do_op(input logic [2:0] f, input logic w, input logic [63:0] x,
                       input logic [63:0] y, output int lat, output logic [63:0] res,
                       output logic rdy_in_done, output logic rdy_after, output logic done_after);
    int cyc;
    @(negedge clk);
    start = 1'b1; op = f; is32 = w; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 3'($urandom_range(0, 7));
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    lat = cyc;
    res = result;
    rdy_in_done = ready;
    @(negedge clk);
    rdy_after = ready;
    done_after = done;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tot++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    tot++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    tot++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    tot++; if (result !== 64'd0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
  endtask

  typedef struct {
    logic [2:0]  f;
    logic        w;
    logic [63:0] x, y, exp;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[11];
    int lat; logic [63:0] res; logic rid, ra, da;
    v[0]  = '{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 67};
    v[1]  = '{3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 67};
    v[2]  = '{3'd1, 1'b0, '1, '1, 64'd0, 67};
    v[3]  = '{3'd4, 1'b0, 64'd100, 64'd0, '1, 2};
    v[4]  = '{3'd7, 1'b0, 64'd100, 64'd0, 64'd100, 2};
    v[5]  = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 2};
    v[6]  = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 2};
    v[7]  = '{3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2};
    v[8]  = '{3'd4, 1'b1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 35};
    v[9]  = '{3'd6, 1'b1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 35};
    v[10] = '{3'd5, 1'b1, 64'hFFFF_FFF9, 64'd2, 64'h7FFF_FFFC, 35};
    for (int i = 0; i < 11; i++) begin
      do_op(v[i].f, v[i].w, v[i].x, v[i].y, lat, res, rid, ra, da);
      last_exp = v[i].exp;
      tot++; if (res !== v[i].exp) begin bad++; $display("FAIL dir%0d_result: got %h want %h", i, res, v[i].exp); end
      tot++; if (lat != v[i].lat) begin bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, v[i].lat); end
      tot++; if (rid !== 1'b0) begin bad++; $display("FAIL dir%0d_ready_in_done: got %b want 0", i, rid); end
      tot++; if (ra !== 1'b1 || da !== 1'b0) begin bad++; $display("FAIL dir%0d_after_done: ready=%b done=%b want 1/0", i, ra, da); end
    end
  endtask

  task automatic test_random();
    int lat, exp_lat; logic [63:0] res, x, y, exp_r; logic rid, ra, da;
    logic [2:0] f; logic w;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      case ($urandom_range(0, 6))
        0: y = {$urandom, 32'd0} & (w ? 64'hFFFF_FFFF_0000_0000 : 64'd0);
        1: begin x = 64'h8000_0000_0000_0000; y = '1; end
        2: begin x = {$urandom, 32'h8000_0000}; y = {$urandom, 32'hFFFF_FFFF}; end
        3: y = 64'($urandom_range(1, 9));
        4: x = 64'($urandom_range(0, 20));
        default: ;
      endcase
      exp_r = ref_result(f, w, x, y);
      exp_lat = ref_latency(f, w, x, y);
      do_op(f, w, x, y, lat, res, rid, ra, da);
      last_exp = exp_r;
      tot++; if (res !== exp_r) begin bad++; $display("FAIL rnd%0d_result op=%0d w=%b a=%h b=%h: got %h want %h", i, f, w, x, y, res, exp_r); end
      tot++; if (lat != exp_lat) begin bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, exp_lat); end
      tot++; if (rid !== 1'b0 || ra !== 1'b1) begin bad++; $display("FAIL rnd%0d_handshake: ready_in_done=%b ready_after=%b want 0/1", i, rid, ra); end
    end
  endtask

  task automatic test_flush();
    int seen;
    // flush together with start in IDLE must not accept
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd0; a = 64'd3; b = 64'd5;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    tot++; if (ready !== 1'b1) begin bad++; $display("FAIL flush_start_idle: ready got %b want 1", ready); end
    // flush in cycle 20 of a divide, with start pulses ignored during CALC
    start = 1'b1; op = 3'd4; is32 = 1'b0; a = {$urandom, $urandom}; b = 64'($urandom_range(3, 999));
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int c = 1; c <= 20; c++) begin
      start = (c == 5 || c == 9 || c == 13);
      if (start) begin op = 3'd0; a = {$urandom, $urandom}; end
      flush = (c == 20);
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    start = 1'b0; flush = 1'b0;
    tot++; if (ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL flush_ready_c21: ready=%b busy=%b want 1/0", ready, busy); end
    for (int c = 0; c < 80; c++) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    tot++; if (seen != 0) begin bad++; $display("FAIL flush_no_done: got %0d done cycles want 0", seen); end
    tot++; if (result !== last_exp) begin bad++; $display("FAIL flush_result_kept: got %h want %h", result, last_exp); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [63:0] res, x, y, exp_r; logic rid, ra, da;
    @(negedge clk);
    start = 1'b1; op = 3'd0; is32 = 1'b0; a = {$urandom, $urandom}; b = {$urandom, $urandom};
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 30; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tot++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_mid_ctrl: ready=%b busy=%b done=%b want 1/0/0", ready, busy, done); end
    tot++; if (result !== 64'd0) begin bad++; $display("FAIL rst_mid_result: got %h want 0", result); end
    last_exp = '0;
    x = {$urandom, $urandom}; y = 64'($urandom_range(1, 1000));
    exp_r = ref_result(3'd7, 1'b0, x, y);
    do_op(3'd7, 1'b0, x, y, lat, res, rid, ra, da);
    last_exp = exp_r;
    tot++; if (res !== exp_r) begin bad++; $display("FAIL rst_next_result: got %h want %h", res, exp_r); end
    tot++; if (lat != 67) begin bad++; $display("FAIL rst_next_latency: got %0d want 67", lat); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [63:0] res, x, y, exp_r; logic rid, ra, da;
    for (int i = 0; i < 4; i++) begin
      x = {$urandom, $urandom}; y = {$urandom, $urandom};
      exp_r = ref_result(3'(i), 1'b1, x, y);
      do_op(3'(i), 1'b1, x, y, lat, res, rid, ra, da);
      last_exp = exp_r;
      tot++; if (res !== exp_r) begin bad++; $display("FAIL b2b%0d_result: got %h want %h", i, res, exp_r); end
      tot++; if (lat != ref_latency(3'(i), 1'b1, x, y)) begin bad++; $display("FAIL b2b%0d_latency: got %0d want %0d", i, lat, ref_latency(3'(i), 1'b1, x, y)); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
